// File: rtl/ddr_axi_arb.sv
// ddr_axi_arb: two-master AXI4 arbiter sharing the single DDR3 controller port.
// Ports: clk / rst_ (synchronous, active-low); m0_* = UART command bridge, m1_* = DMA client,
// each with AW/W/B and AR/R channels; s_* = mirrored slave-side port toward ddr3_top.
// Write and read directions arbitrate independently, one outstanding transaction each.
// Build option DDR_ARB_RR_EN: round-robin tie-break per direction; undefined = master 0 wins ties.
module ddr_axi_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [AW-1:0]   m0_awaddr,
  input  logic [7:0]      m0_awlen,
  input  logic            m0_awvalid,
  output logic            m0_awready,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  input  logic            m0_wlast,
  input  logic            m0_wvalid,
  output logic            m0_wready,
  output logic            m0_bvalid,
  input  logic            m0_bready,
  input  logic [AW-1:0]   m0_araddr,
  input  logic [7:0]      m0_arlen,
  input  logic            m0_arvalid,
  output logic            m0_arready,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_rlast,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  input  logic [AW-1:0]   m1_awaddr,
  input  logic [7:0]      m1_awlen,
  input  logic            m1_awvalid,
  output logic            m1_awready,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_wlast,
  input  logic            m1_wvalid,
  output logic            m1_wready,
  output logic            m1_bvalid,
  input  logic            m1_bready,
  input  logic [AW-1:0]   m1_araddr,
  input  logic [7:0]      m1_arlen,
  input  logic            m1_arvalid,
  output logic            m1_arready,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_rlast,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  output logic [3:0]      s_awid,
  output logic [AW-1:0]   s_awaddr,
  output logic [7:0]      s_awlen,
  output logic [1:0]      s_awburst,
  output logic            s_awvalid,
  input  logic            s_awready,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  output logic            s_wlast,
  output logic            s_wvalid,
  input  logic            s_wready,
  input  logic            s_bvalid,
  output logic            s_bready,
  output logic [3:0]      s_arid,
  output logic [AW-1:0]   s_araddr,
  output logic [7:0]      s_arlen,
  output logic [1:0]      s_arburst,
  output logic            s_arvalid,
  input  logic            s_arready,
  input  logic [DW-1:0]   s_rdata,
  input  logic            s_rlast,
  input  logic            s_rvalid,
  output logic            s_rready
);
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic wgnt, rgnt, wpick, rpick, w_req, r_req;
  logic w_addr, w_data, w_resp, r_addr, r_data;
  assign w_req = (w_state == W_IDLE) && (m0_awvalid || m1_awvalid);
  assign r_req = (r_state == R_IDLE) && (m0_arvalid || m1_arvalid);
`ifdef DDR_ARB_RR_EN
  // Pointer holds the master granted last; a tie goes to the other one.
  logic wlast_gnt, rlast_gnt;
  assign wpick = (m0_awvalid && m1_awvalid) ? !wlast_gnt : !m0_awvalid;
  assign rpick = (m0_arvalid && m1_arvalid) ? !rlast_gnt : !m0_arvalid;
  always_ff @(posedge clk) begin
    if (!rst_) begin
      wlast_gnt <= 1'b1;
      rlast_gnt <= 1'b1;
    end else begin
      if (w_req) wlast_gnt <= wpick;
      if (r_req) rlast_gnt <= rpick;
    end
  end
`else
  assign wpick = !m0_awvalid;
  assign rpick = !m0_arvalid;
`endif
  always_ff @(posedge clk) begin
    if (!rst_) begin
      w_state <= W_IDLE;
      wgnt    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (w_req) begin
          wgnt    <= wpick;
          w_state <= W_ADDR;
        end
        W_ADDR:  if (s_awvalid && s_awready) w_state <= W_DATA;
        W_DATA:  if (s_wvalid && s_wready && s_wlast) w_state <= W_RESP;
        W_RESP:  if (s_bvalid && s_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state <= R_IDLE;
      rgnt    <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (r_req) begin
          rgnt    <= rpick;
          r_state <= R_ADDR;
        end
        R_ADDR:  if (s_arvalid && s_arready) r_state <= R_DATA;
        R_DATA:  if (s_rvalid && s_rready && s_rlast) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end
  assign w_addr = w_state == W_ADDR;
  assign w_data = w_state == W_DATA;
  assign w_resp = w_state == W_RESP;
  assign r_addr = r_state == R_ADDR;
  assign r_data = r_state == R_DATA;
  // Payloads follow the grant unconditionally; only valid/ready are phase-gated.
  assign s_awid     = '0;
  assign s_awburst  = 2'b01;
  assign s_awaddr   = wgnt ? m1_awaddr : m0_awaddr;
  assign s_awlen    = wgnt ? m1_awlen : m0_awlen;
  assign s_awvalid  = w_addr && (wgnt ? m1_awvalid : m0_awvalid);
  assign m0_awready = w_addr && !wgnt && s_awready;
  assign m1_awready = w_addr && wgnt && s_awready;
  assign s_wdata    = wgnt ? m1_wdata : m0_wdata;
  assign s_wstrb    = wgnt ? m1_wstrb : m0_wstrb;
  assign s_wlast    = wgnt ? m1_wlast : m0_wlast;
  assign s_wvalid   = w_data && (wgnt ? m1_wvalid : m0_wvalid);
  assign m0_wready  = w_data && !wgnt && s_wready;
  assign m1_wready  = w_data && wgnt && s_wready;
  assign s_bready   = w_resp && (wgnt ? m1_bready : m0_bready);
  assign m0_bvalid  = w_resp && !wgnt && s_bvalid;
  assign m1_bvalid  = w_resp && wgnt && s_bvalid;
  assign s_arid     = '0;
  assign s_arburst  = 2'b01;
  assign s_araddr   = rgnt ? m1_araddr : m0_araddr;
  assign s_arlen    = rgnt ? m1_arlen : m0_arlen;
  assign s_arvalid  = r_addr && (rgnt ? m1_arvalid : m0_arvalid);
  assign m0_arready = r_addr && !rgnt && s_arready;
  assign m1_arready = r_addr && rgnt && s_arready;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_rlast   = s_rlast;
  assign m1_rlast   = s_rlast;
  assign m0_rvalid  = r_data && !rgnt && s_rvalid;
  assign m1_rvalid  = r_data && rgnt && s_rvalid;
  assign s_rready   = r_data && (rgnt ? m1_rready : m0_rready);
endmodule

// File: tb/tb_ddr_axi_arb.sv
// tb_ddr_axi_arb: directed scoreboard bench for ddr_axi_arb with two master drivers and a DDR slave model.
module tb_ddr_axi_arb;
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
  logic [7:0]  awlen [2], arlen [2];
  logic [3:0]  wstrb [2];
  logic awvalid [2], awready [2], wlast [2], wvalid [2], wready [2], bvalid [2], bready [2];
  logic arvalid [2], arready [2], rlast [2], rvalid [2], rready [2];
  logic [3:0]  s_awid, s_arid, s_wstrb;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [7:0]  s_awlen, s_arlen;
  logic [1:0]  s_awburst, s_arburst;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [14:0] outs;
  int tests = 0, fails = 0;
  logic [39:0] awq [$];
  logic [32:0] wq [$], rq [$];
  logic w_bp = 1'b0;
  ddr_axi_arb #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_(rst_),
    .m0_awaddr(awaddr[0]), .m0_awlen(awlen[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready[0]),
    .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wlast(wlast[0]), .m0_wvalid(wvalid[0]), .m0_wready(wready[0]),
    .m0_bvalid(bvalid[0]), .m0_bready(bready[0]),
    .m0_araddr(araddr[0]), .m0_arlen(arlen[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
    .m0_rdata(rdata[0]), .m0_rlast(rlast[0]), .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
    .m1_awaddr(awaddr[1]), .m1_awlen(awlen[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready[1]),
    .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wlast(wlast[1]), .m1_wvalid(wvalid[1]), .m1_wready(wready[1]),
    .m1_bvalid(bvalid[1]), .m1_bready(bready[1]),
    .m1_araddr(araddr[1]), .m1_arlen(arlen[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
    .m1_rdata(rdata[1]), .m1_rlast(rlast[1]), .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );
  assign outs = {awready[0], awready[1], wready[0], wready[1], bvalid[0], bvalid[1], arready[0], arready[1],
                 rvalid[0], rvalid[1], s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready};
  function automatic logic [31:0] rd(input logic [31:0] a, input int i);
    return (a + 32'(i * 4)) ^ 32'hDEADBFEF;
  endfunction
  function automatic logic [31:0] wd(input logic [31:0] a, input int i);
    return a + 32'(i) + 32'hC0DE0000;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_rd(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) rq.push_back({i == n - 1, rd(a, i)});
  endtask
  // Every driver task is entered at a negedge, drives there, and samples at negedge+1.
  task automatic aw_req(input int m, input logic [31:0] a, input int n, output int lat);
    logic hs;
    awaddr[m] = a; awlen[m] = 8'(n - 1); awvalid[m] = 1'b1; lat = 0;
    do begin #1; hs = awready[m]; @(negedge clk); lat++; end while (!hs && lat < 200);
    awvalid[m] = 1'b0;
    chk("aw_handshake", 64'(hs), 64'd1);
  endtask
  task automatic w_beats(input int m, input logic [31:0] a, input int n, input int k);
    logic hs;
    int c;
    for (int i = 0; i < k; i++) begin
      wdata[m] = wd(a, i); wstrb[m] = 4'hF; wlast[m] = (i == n - 1); wvalid[m] = 1'b1;
      wq.push_back({wlast[m], wdata[m]});
      c = 0;
      do begin #1; hs = wready[m]; @(negedge clk); c++; end while (!hs && c < 200);
      chk("w_handshake", 64'(hs), 64'd1);
    end
    wvalid[m] = 1'b0; wlast[m] = 1'b0;
  endtask
  task automatic b_wait(input int m);
    logic hs;
    int c;
    bready[m] = 1'b1; c = 0;
    do begin
      #1; hs = bvalid[m];
      if (hs) chk("b_other_master", 64'(bvalid[1 - m]), 64'd0);
      @(negedge clk); c++;
    end while (!hs && c < 200);
    bready[m] = 1'b0;
    chk("b_received", 64'(hs), 64'd1);
  endtask
  task automatic write(input int m, input logic [31:0] a, input int n, output int lat);
    aw_req(m, a, n, lat);
    w_beats(m, a, n, n);
    b_wait(m);
  endtask
  task automatic ar_req(input int m, input logic [31:0] a, input int n, output int lat);
    logic hs;
    araddr[m] = a; arlen[m] = 8'(n - 1); arvalid[m] = 1'b1; lat = 0;
    do begin #1; hs = arready[m]; @(negedge clk); lat++; end while (!hs && lat < 200);
    arvalid[m] = 1'b0;
    chk("ar_handshake", 64'(hs), 64'd1);
  endtask
  task automatic r_recv(input int m, input int n, input int stall);
    int got, c, st;
    logic [32:0] e;
    got = 0; c = 0; st = stall; rready[m] = (st == 0);
    while (got < n && c < 300) begin
      #1;
      chk("s_rready_follow", 64'(s_rready), 64'(rready[m]));
      if (rvalid[m] && rready[m]) begin
        e = 'x;
        if (rq.size() > 0) e = rq.pop_front();
        chk("r_beat", 64'({rlast[m], rdata[m]}), 64'(e));
        chk("r_other_master", 64'(rvalid[1 - m]), 64'd0);
        got++;
      end
      @(negedge clk); c++;
      if (st > 0) begin st--; rready[m] = (st == 0); end
    end
    rready[m] = 1'b0;
    chk("r_beats_done", 64'(got), 64'(n));
  endtask
  task automatic read(input int m, input logic [31:0] a, input int n, input int stall, output int lat);
    ar_req(m, a, n, lat);
    r_recv(m, n, stall);
  endtask
  // DDR slave model: always accepts addresses, returns B after the last W beat,
  // streams arlen+1 read beats held under rready, optionally toggles wready.
  initial begin : slave
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wl;
    logic [31:0] ara, rbase;
    logic [7:0] arl;
    logic [39:0] ea;
    logic [32:0] ew;
    int rrem, rbeat;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; wl = 0;
    ara = 0; arl = 0; rbase = 0; rrem = 0; rbeat = 0;
    s_awready = 1'b1; s_arready = 1'b1; s_wready = 1'b1;
    s_bvalid = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_) begin
        s_bvalid = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; rrem = 0;
      end else begin
        if (b_hs) s_bvalid = 1'b0;
        if (w_hs && wl) s_bvalid = 1'b1;
        if (r_hs) begin rrem--; rbeat++; end
        if (ar_hs) begin rrem = int'(arl) + 1; rbeat = 0; rbase = ara; end
        s_rvalid = rrem > 0; s_rlast = rrem == 1; s_rdata = rd(rbase, rbeat);
      end
      s_wready = w_bp ? !s_wready : 1'b1;
      #1;
      aw_hs = rst_ && s_awvalid && s_awready;
      w_hs  = rst_ && s_wvalid && s_wready;
      b_hs  = rst_ && s_bvalid && s_bready;
      ar_hs = rst_ && s_arvalid && s_arready;
      r_hs  = rst_ && s_rvalid && s_rready;
      wl = s_wlast; ara = s_araddr; arl = s_arlen;
      if (aw_hs) begin
        ea = 'x;
        if (awq.size() > 0) ea = awq.pop_front();
        chk("aw_grant_order", 64'({s_awlen, s_awaddr}), 64'(ea));
        chk("aw_burst_id", 64'({s_awburst, s_awid}), 64'({2'b01, 4'h0}));
      end
      if (w_hs) begin
        ew = 'x;
        if (wq.size() > 0) ew = wq.pop_front();
        chk("w_beat", 64'({s_wlast, s_wdata}), 64'(ew));
      end
      if (ar_hs) chk("ar_burst_id", 64'({s_arburst, s_arid}), 64'({2'b01, 4'h0}));
    end
  end
  initial begin
    int l0, l1;
    for (int m = 0; m < 2; m++) begin
      awaddr[m] = '0; awlen[m] = '0; awvalid[m] = 0; wdata[m] = '0; wstrb[m] = '0;
      wlast[m] = 0; wvalid[m] = 0; bready[m] = 0; araddr[m] = '0; arlen[m] = '0;
      arvalid[m] = 0; rready[m] = 0;
    end
    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", 64'(outs), 64'd0);
    @(negedge clk);
    // single read from m0 issued in the reset-release cycle
    rst_ = 1'b1; push_rd(32'h100, 1);
    araddr[0] = 32'h100; arlen[0] = 8'd0; arvalid[0] = 1'b1;
    #1 chk("ar_release_cycle", 64'(s_arvalid), 64'd0);
    @(negedge clk);
    #1;
    chk("ar_cycle1_valid", 64'(s_arvalid), 64'd1);
    chk("ar_cycle1_addr", 64'(s_araddr), 64'h100);
    chk("ar_ready_routing", 64'({arready[0], arready[1]}), 64'b10);
    @(negedge clk);
    arvalid[0] = 1'b0;
    r_recv(0, 1, 0);
    // simultaneous 4-beat writes, repeated pairs
    for (int p = 0; p < 2; p++) begin
      awq.push_back({8'd3, 32'h1000 + 32'(p * 256)});
      awq.push_back({8'd3, 32'h2000 + 32'(p * 256)});
      fork
        write(0, 32'h1000 + 32'(p * 256), 4, l0);
        write(1, 32'h2000 + 32'(p * 256), 4, l1);
      join
      chk("tie_pair_m0_lat", 64'(l0), 64'd2);
    end
    // m0 wins alone, then a tie decides between fixed priority and round-robin
    awq.push_back({8'd3, 32'h1200});
    write(0, 32'h1200, 4, l0);
    chk("solo_w_lat", 64'(l0), 64'd2);
`ifdef DDR_ARB_RR_EN
    awq.push_back({8'd3, 32'h2200}); awq.push_back({8'd3, 32'h1300});
`else
    awq.push_back({8'd3, 32'h1300}); awq.push_back({8'd3, 32'h2200});
`endif
    fork
      write(0, 32'h1300, 4, l0);
      write(1, 32'h2200, 4, l1);
    join
`ifdef DDR_ARB_RR_EN
    chk("w_tie_winner_lat", 64'(l1), 64'd2);
`else
    chk("w_tie_winner_lat", 64'(l0), 64'd2);
`endif
    // overlapping write (m0) and read (m1)
    awq.push_back({8'd3, 32'h400}); push_rd(32'h300, 4);
    fork
      write(0, 32'h400, 4, l0);
      read(1, 32'h300, 4, 0, l1);
    join
    chk("overlap_w_lat", 64'(l0), 64'd2);
    chk("overlap_r_lat", 64'(l1), 64'd2);
    // wready toggling and m0 rready held low for 5 cycles
    w_bp = 1'b1;
    awq.push_back({8'd3, 32'h500}); push_rd(32'h600, 4);
    fork
      write(0, 32'h500, 4, l0);
      read(0, 32'h600, 4, 5, l1);
    join
    w_bp = 1'b0;
    // read tie after m0 was granted last
`ifdef DDR_ARB_RR_EN
    push_rd(32'h800, 2); push_rd(32'h700, 2);
`else
    push_rd(32'h700, 2); push_rd(32'h800, 2);
`endif
    fork
      read(0, 32'h700, 2, 0, l0);
      read(1, 32'h800, 2, 0, l1);
    join
`ifdef DDR_ARB_RR_EN
    chk("r_tie_winner_lat", 64'(l1), 64'd2);
`else
    chk("r_tie_winner_lat", 64'(l0), 64'd2);
`endif
    // reset after 2 of 4 write beats, with m1 requesting across the reset
    awq.push_back({8'd3, 32'h900});
    aw_req(0, 32'h900, 4, l0);
    w_beats(0, 32'h900, 4, 2);
    rst_ = 1'b0; wvalid[0] = 1'b1; wdata[0] = wd(32'h900, 2);
    awaddr[1] = 32'hA00; awlen[1] = 8'd3; awvalid[1] = 1'b1;
    @(negedge clk);
    #1 chk("mid_reset_outputs", 64'(outs), 64'd0);
    @(negedge clk);
    rst_ = 1'b1; wvalid[0] = 1'b0;
    awq.push_back({8'd3, 32'hA00});
    write(1, 32'hA00, 4, l1);
    chk("post_reset_m1_lat", 64'(l1), 64'd2);
    chk("awq_drained", 64'(awq.size()), 64'd0);
    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
